// File: rtl/frame_pad_writer_if.sv
// Pixel-in / word-out handshake bundle for frame_pad_writer.
// master is the writer block, slave is the pixel source plus the bus it writes to.
interface frame_pad_writer_if;
    logic        iStart;
    logic [7:0]  iPixel;
    logic        iPixelValid;
    logic        oPixelReady;
    logic [18:0] write_addr;
    logic [31:0] iData;
    logic        iValid;
    logic        iWaitrequest;
    logic        oBusy;
    logic        oFrameDone;

    modport master (
        input  iStart, iPixel, iPixelValid, iWaitrequest,
        output oPixelReady, write_addr, iData, iValid, oBusy, oFrameDone
    );

    modport slave (
        output iStart, iPixel, iPixelValid, iWaitrequest,
        input  oPixelReady, write_addr, iData, iValid, oBusy, oFrameDone
    );
endinterface

// File: rtl/frame_pad_writer.sv
// Wraps a WIDTHxHEIGHT pixel stream in a one-byte PAD_VALUE border and writes it as little-endian 32-bit words.
// One byte per unstalled cycle; a word appears the cycle after its 4th byte and is held while iWaitrequest stalls it.
module frame_pad_writer #(
    parameter int          WIDTH     = 320,
    parameter int          HEIGHT    = 240,
    parameter logic [18:0] BASE_ADDR = 19'd0,
    parameter logic [7:0]  PAD_VALUE = 8'h00
) (
    input  logic                 d5m_clk,
    input  logic                 reset,
    frame_pad_writer_if.master   bus
);

    localparam int CW = $clog2(WIDTH + 2) + 1;
    localparam int RW = $clog2(HEIGHT + 1) + 1;

    typedef enum logic [2:0] {IDLE, TOP, LEFT, PIX, RIGHT, BOTTOM, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col_cnt, col_nxt;
    logic [RW-1:0] row_cnt, row_nxt;
    logic [1:0]    lane;
    logic [23:0]   word_buf;
    logic [18:0]   next_addr;
    logic [7:0]    byte_dat;
    logic          stall, accept, byte_en, start, frame_done;

    assign stall  = bus.iValid && bus.iWaitrequest;
    assign accept = bus.iValid && !bus.iWaitrequest;

    always_ff @(posedge d5m_clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            state   <= state_nxt;
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        col_nxt    = col_cnt;
        row_nxt    = row_cnt;
        byte_en    = 1'b0;
        byte_dat   = PAD_VALUE;
        start      = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    state_nxt = TOP;
                    col_nxt   = '0;
                    row_nxt   = '0;
                    start     = 1'b1;
                end
            end
            TOP: begin
                byte_en = !stall;
                if (byte_en) begin
                    if (col_cnt == CW'(WIDTH + 1)) begin
                        state_nxt = LEFT;
                        col_nxt   = '0;
                    end else begin
                        col_nxt = col_cnt + CW'(1);
                    end
                end
            end
            LEFT: begin
                byte_en = !stall;
                if (byte_en) state_nxt = PIX;
            end
            PIX: begin
                byte_en  = !stall && bus.iPixelValid;
                byte_dat = bus.iPixel;
                if (byte_en) begin
                    if (col_cnt == CW'(WIDTH - 1)) begin
                        state_nxt = RIGHT;
                        col_nxt   = '0;
                    end else begin
                        col_nxt = col_cnt + CW'(1);
                    end
                end
            end
            RIGHT: begin
                byte_en = !stall;
                if (byte_en) begin
                    if (row_cnt == RW'(HEIGHT - 1)) begin
                        state_nxt = BOTTOM;
                        row_nxt   = '0;
                    end else begin
                        state_nxt = LEFT;
                        row_nxt   = row_cnt + RW'(1);
                    end
                end
            end
            BOTTOM: begin
                byte_en = !stall;
                if (byte_en) begin
                    if (col_cnt == CW'(WIDTH + 1)) begin
                        state_nxt = FLUSH;
                        col_nxt   = '0;
                    end else begin
                        col_nxt = col_cnt + CW'(1);
                    end
                end
            end
            FLUSH: begin
                // Odd frame sizes leave a partial word: fill its upper lanes with pad first.
                byte_en = (lane != 2'd0) && !stall;
                if ((lane == 2'd0) && !stall) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge d5m_clk or posedge reset) begin
        if (reset) begin
            lane           <= 2'd0;
            word_buf       <= '0;
            next_addr      <= BASE_ADDR;
            bus.iData      <= '0;
            bus.write_addr <= BASE_ADDR;
            bus.iValid     <= 1'b0;
        end else begin
            if (start) begin
                lane      <= 2'd0;
                next_addr <= BASE_ADDR;
            end else if (byte_en) begin
                if (lane == 2'd3) begin
                    bus.iData      <= {byte_dat, word_buf};
                    bus.write_addr <= next_addr;
                    next_addr      <= next_addr + 19'd4;
                end else begin
                    word_buf[{lane, 3'b000} +: 8] <= byte_dat;
                end
                lane <= lane + 2'd1;
            end
            // A completing word can only be produced when the held one is leaving, so no bubble is needed.
            if (byte_en && (lane == 2'd3))
                bus.iValid <= 1'b1;
            else if (accept)
                bus.iValid <= 1'b0;
        end
    end

    assign bus.oPixelReady = (state == PIX) && !stall;
    assign bus.oBusy       = (state != IDLE);
    assign bus.oFrameDone  = frame_done;

endmodule

// File: tb/tb_frame_pad_writer.sv
// Randomized bench for frame_pad_writer against a byte-array model of the padded frame.
module tb_frame_pad_writer;

    localparam int          W     = 16;
    localparam int          H     = 6;
    localparam logic [18:0] BASE  = 19'd0;
    localparam logic [7:0]  PAD   = 8'h00;
    localparam int          W2    = 5;
    localparam int          H2    = 3;
    localparam logic [18:0] BASE2 = 19'h7FFF0;
    localparam logic [7:0]  PAD2  = 8'hEE;
    localparam int          BUDGET = 3000;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic d5m_clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    frame_pad_writer_if bus();
    frame_pad_writer_if bus2();

    frame_pad_writer #(.WIDTH(W), .HEIGHT(H), .BASE_ADDR(BASE), .PAD_VALUE(PAD)) dut (
        .d5m_clk (d5m_clk),
        .reset   (reset),
        .bus     (bus)
    );

    frame_pad_writer #(.WIDTH(W2), .HEIGHT(H2), .BASE_ADDR(BASE2), .PAD_VALUE(PAD2)) dut2 (
        .d5m_clk (d5m_clk),
        .reset   (reset),
        .bus     (bus2)
    );

    always #5 d5m_clk = ~d5m_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Lay out the whole bordered frame as bytes, pad to a word multiple, pack little-endian.
    function automatic wq_t build_words(input int w, input int h, input logic [7:0] pad, input bq_t pix);
        bq_t b;
        wq_t q;
        int  k = 0;
        for (int r = 0; r < h + 2; r++)
            for (int c = 0; c < w + 2; c++)
                if (r == 0 || r == h + 1 || c == 0 || c == w + 1) b.push_back(pad);
                else begin
                    b.push_back(pix[k]);
                    k++;
                end
        while (b.size() % 4 != 0) b.push_back(pad);
        for (int i = 0; i < b.size() / 4; i++)
            q.push_back({b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]});
        return q;
    endfunction

    // vmode: 0 always valid, 1 toggle, 2 random. wmode: 0 none, 1 random, 2 five-cycle stall at addr 16.
    task automatic run_frame(input int vmode, input int wmode, input int rst_word, input bit extra_start);
        bq_t         pix;
        wq_t         exp_q;
        wq_t         got;
        int          pi = 0, nw = 0, ndone = 0, cyc = 0, stall_left = 0;
        bit          stall_done = 0, was_stall = 0;
        logic [31:0] last_dat = '0;
        logic [18:0] last_addr = '0;
        logic [18:0] ea;

        for (int i = 0; i < W * H; i++) pix.push_back(8'($urandom));
        pix[0] = 8'hA5; pix[1] = 8'h01; pix[2] = 8'h02; pix[3] = 8'h03; pix[4] = 8'h04;
        pix[13] = 8'h11; pix[14] = 8'h22; pix[15] = 8'h33;
        exp_q = build_words(W, H, PAD, pix);

        @(negedge d5m_clk);
        bus.iWaitrequest = 1'b0;
        bus.iPixelValid  = 1'b0;
        bus.iStart       = 1'b1;
        @(negedge d5m_clk);
        bus.iStart = 1'b0;
        #1 check_eq("busy_after_start", 32'(bus.oBusy), 32'd1);

        while (ndone == 0 && cyc < BUDGET) begin
            @(negedge d5m_clk);
            cyc++;
            bus.iPixel = (pi < pix.size()) ? pix[pi] : 8'h00;
            case (vmode)
                0:       bus.iPixelValid = 1'b1;
                1:       bus.iPixelValid = (cyc % 2) == 0;
                default: bus.iPixelValid = 1'($urandom_range(0, 1));
            endcase
            if (wmode == 2) begin
                if (stall_left > 0) begin
                    bus.iWaitrequest = 1'b1;
                    stall_left--;
                end else if (!stall_done && bus.iValid && bus.write_addr == 19'd16) begin
                    bus.iWaitrequest = 1'b1;
                    stall_left = 4;
                    stall_done = 1;
                end else bus.iWaitrequest = 1'b0;
            end else if (wmode == 1) bus.iWaitrequest = ($urandom_range(0, 3) == 0);
            else bus.iWaitrequest = 1'b0;
            bus.iStart = extra_start && (cyc == 20);
            #1;
            if (was_stall) begin
                check_eq("stall_hold_vld", 32'(bus.iValid), 32'd1);
                check_eq("stall_hold_dat", bus.iData, last_dat);
                check_eq("stall_hold_addr", 32'(bus.write_addr), 32'(last_addr));
            end
            if (bus.iValid && bus.iWaitrequest) begin
                check_eq("stall_rdy_low", 32'(bus.oPixelReady), 32'd0);
                was_stall = 1;
                last_dat  = bus.iData;
                last_addr = bus.write_addr;
            end else was_stall = 0;
            if (bus.iValid && !bus.iWaitrequest) begin
                ea = BASE + 19'(4 * nw);
                check_eq("word_addr", 32'(bus.write_addr), 32'(ea));
                check_eq("word_dat", bus.iData, (nw < exp_q.size()) ? exp_q[nw] : 32'hDEAD_BEEF);
                got.push_back(bus.iData);
                nw++;
            end
            if (bus.oFrameDone) begin
                ndone++;
                check_eq("done_at_last_word", nw, exp_q.size());
            end
            if (bus.iPixelValid && bus.oPixelReady) pi++;
            if (rst_word > 0 && nw == rst_word) break;
        end
        bus.iStart = 1'b0;

        if (rst_word > 0) begin
            reset = 1'b1;
            #1;
            check_eq("rst_vld", 32'(bus.iValid), 32'd0);
            check_eq("rst_busy", 32'(bus.oBusy), 32'd0);
            check_eq("rst_rdy", 32'(bus.oPixelReady), 32'd0);
            check_eq("rst_addr", 32'(bus.write_addr), 32'(BASE));
            check_eq("rst_dat", bus.iData, 32'd0);
            @(negedge d5m_clk);
            reset = 1'b0;
        end else begin
            check_eq("done_pulse", ndone, 1);
            check_eq("word_count", nw, exp_q.size());
            check_eq("pix_consumed", pi, W * H);
            if (got.size() == 36) begin
                check_eq("first_word", got[0], 32'h0000_0000);
                check_eq("word_addr16", got[4], 32'hA500_0000);
                check_eq("word_addr20", got[5], 32'h0403_0201);
                check_eq("word_addr32", got[8], 32'h0033_2211);
                check_eq("row1_pix0_lane1", 32'(got[9][15:8]), 32'(pix[W]));
            end
            @(negedge d5m_clk);
            bus.iPixelValid  = 1'b0;
            bus.iWaitrequest = 1'b0;
            #1;
            check_eq("idle_busy", 32'(bus.oBusy), 32'd0);
            check_eq("idle_vld", 32'(bus.iValid), 32'd0);
            check_eq("idle_done", 32'(bus.oFrameDone), 32'd0);
        end
    endtask

    // Odd-size frame: exercises the partial final word, a non-zero pad byte and address wrap.
    task automatic run_small();
        bq_t pix;
        wq_t exp_q;
        int  pi = 0, nw = 0, nd = 0, cyc = 0;
        logic [18:0] ea;
        for (int i = 0; i < W2 * H2; i++) pix.push_back(8'($urandom));
        exp_q = build_words(W2, H2, PAD2, pix);
        @(negedge d5m_clk);
        bus2.iStart = 1'b1;
        @(negedge d5m_clk);
        bus2.iStart = 1'b0;
        while (nd == 0 && cyc < BUDGET) begin
            @(negedge d5m_clk);
            cyc++;
            bus2.iPixel       = (pi < pix.size()) ? pix[pi] : 8'h00;
            bus2.iPixelValid  = 1'b1;
            bus2.iWaitrequest = ($urandom_range(0, 2) == 0);
            #1;
            if (bus2.iValid && !bus2.iWaitrequest) begin
                ea = BASE2 + 19'(4 * nw);
                check_eq("small_addr", 32'(bus2.write_addr), 32'(ea));
                check_eq("small_dat", bus2.iData, (nw < exp_q.size()) ? exp_q[nw] : 32'hDEAD_BEEF);
                if (nw == 4) check_eq("small_addr_wrap", 32'(bus2.write_addr), 32'd0);
                nw++;
            end
            if (bus2.oFrameDone) nd++;
            if (bus2.iPixelValid && bus2.oPixelReady) pi++;
        end
        check_eq("small_done", nd, 1);
        check_eq("small_words", nw, 9);
        check_eq("small_pix", pi, W2 * H2);
    endtask

    initial begin
        reset             = 1'b1;
        bus.iStart        = 1'b0;
        bus.iPixel        = '0;
        bus.iPixelValid   = 1'b0;
        bus.iWaitrequest  = 1'b0;
        bus2.iStart       = 1'b0;
        bus2.iPixel       = '0;
        bus2.iPixelValid  = 1'b0;
        bus2.iWaitrequest = 1'b0;
        #2;
        check_eq("reset_vld", 32'(bus.iValid), 32'd0);
        check_eq("reset_dat", bus.iData, 32'd0);
        check_eq("reset_addr", 32'(bus.write_addr), 32'(BASE));
        check_eq("reset_rdy", 32'(bus.oPixelReady), 32'd0);
        check_eq("reset_busy", 32'(bus.oBusy), 32'd0);
        check_eq("reset_done", 32'(bus.oFrameDone), 32'd0);
        check_eq("reset_addr2", 32'(bus2.write_addr), 32'(BASE2));
        @(negedge d5m_clk);
        reset = 1'b0;

        run_frame(0, 0, 0, 0);
        run_frame(0, 2, 0, 0);
        run_frame(1, 0, 0, 0);
        run_frame(2, 1, 0, 0);
        run_frame(2, 1, 10, 0);
        run_frame(0, 1, 0, 1);
        run_small();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
